// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-request memory slave with programmable wait states
module mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;

  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;

  logic [31:0] mem [DEPTH];

  logic              accept;
  logic              do_access;
  logic              acc_we;
  logic              acc_err;
  logic [31:0]       acc_addr;
  logic [31:0]       acc_wdata;
  logic [3:0]        acc_be;
  logic [ADDR_W-1:0] acc_idx;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  // With zero wait states the access happens on the accepting edge, so it must
  // use the live request; otherwise it uses the copy latched at accept.
  always_comb begin
    acc_we    = lat_we;
    acc_addr  = lat_addr;
    acc_wdata = lat_wdata;
    acc_be    = lat_be;
    if (state == IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end
  end

  assign acc_idx   = acc_addr[ADDR_W+1:2];
  assign acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr[31:ADDR_W+2] != '0);
  assign do_access = ((state == IDLE) && accept && (WAIT_CYCLES == 0)) ||
                     ((state == BUSY) && (cnt == 4'd1));

  // Control FSM, wait counter, request latch and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
            if (WAIT_CYCLES == 0) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= BUSY;
              cnt   <= 4'(WAIT_CYCLES);
            end
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (do_access) begin
        rsp_err   <= acc_err;
        rsp_rdata <= (acc_err || acc_we) ? 32'h0 : mem[acc_idx];
      end
    end
  end

  // Byte-lane writes; reset blocks the commit so a write still waiting is dropped.
  always_ff @(posedge clk) begin
    if (!rst && do_access && !acc_err && acc_we) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Unified instruction/data memory slave answering the multicycle core's memory requests. Accepts one request at a time over a valid/ready handshake and inserts a programmable number of wait states. It performs byte-enabled 32-bit writes or word reads, then holds a registered response until the requester takes it. Sits between the core's address/write-data path and storage, on the responder side of the core's fetch/load/store traffic.

## Interface

- ADDR_W, 10, word-address bits; memory depth DEPTH = 2**ADDR_W 32-bit words.
- WAIT_CYCLES, 2, wait states inserted between accept and access; legal range 0..15.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  requester presents a request.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_wdata  in  32  write data.
- req_be  in  4  byte enables; bit i enables wdata[8i+7:8i].
- rsp_valid  out  1  response available.
- rsp_ready  in  1  requester takes the response.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  request was misaligned or out of range.

## Operation

- States: IDLE, BUSY, RESP. The state register resets to IDLE.
- Accept rule: a request is accepted when req_valid and req_ready are both 1 on a rising edge. At acceptance the block latches req_we, req_addr, req_wdata and req_be. While not in IDLE, request inputs are ignored.
- IDLE -> BUSY on accept when WAIT_CYCLES > 0. The wait counter loads WAIT_CYCLES.
- IDLE -> RESP on accept when WAIT_CYCLES = 0. The access is performed at the accepting edge.
- BUSY: the counter decrements each cycle. On the edge where counter = 1, the access is performed and the state goes BUSY -> RESP.
- Access, evaluated on the latched request:
  - err = (addr[1:0] != 0) or (addr[31:2] >= DEPTH).
  - err: no write; rsp_rdata = 0; rsp_err = 1.
  - read: rsp_rdata = mem[addr[ADDR_W+1:2]]; rsp_err = 0.
  - write: each lane with be[i] = 1 is updated; other lanes are unchanged. rsp_rdata = 0; rsp_err = 0.
- RESP: rsp_valid = 1. rsp_rdata and rsp_err are registered and held stable until rsp_valid && rsp_ready. On that edge the state goes RESP -> IDLE.
- rsp_ready is ignored outside RESP.
- Memory array contents are not reset. rst affects control, the counter and the response registers only.
- Counter width: 4 bits.

## Timing

- Reset values: rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, counter = 0. req_ready = 1 from the first cycle after the reset edge, because the state is IDLE.
- Latency: for an accept at edge N, rsp_valid rises after edge N+WAIT_CYCLES. It stays high until the consuming edge.
- Write commit edge: a write commits on the same edge that raises rsp_valid.
- Read-after-write: a read accepted after a write's response is consumed returns the new data.
- Minimum transaction period: WAIT_CYCLES + 2 cycles. This comprises the accept cycle, WAIT_CYCLES busy cycles, and at least one RESP cycle. It is reached when rsp_ready is held at 1.
- Response consumed in RESP: req_ready stays 0 in that cycle. The next request is accepted no earlier than the following cycle.
- Response backpressure: if rsp_ready stays 0 for any number of cycles, the response is held unchanged and no new request is accepted.
- Reset mid-operation: state returns to IDLE and rsp_valid drops after the reset edge.
  - A write still in BUSY is discarded and never committed.
  - A write already committed (state RESP) remains in memory.
- All-zero byte enables: a write with be = 4'b0000 completes normally with rsp_err = 0 and modifies no memory.
- Highest legal address: 4*(DEPTH-1) = 0xFFC for ADDR_W = 10 is legal. 0x1000 is out of range.

## Test plan

- Reset, then write 0xDEADBEEF to 0x010 with be = 1111 and rsp_ready = 1, WAIT_CYCLES = 2 -> rsp_valid high exactly 2 cycles after the accept edge, for 1 cycle, with rsp_err = 0. Then read 0x010 -> rsp_rdata = 0xDEADBEEF.
- Write 0x11223344 to 0x020, then write 0xAABBCCDD to 0x020 with be = 0101, then read 0x020 -> rsp_rdata = 0x11BB33DD.
- Read at 0x013 (misaligned), then write to 0x1000 (out of range) -> both give rsp_err = 1 and rsp_rdata = 0. A subsequent read of 0x000 shows no corruption (value previously written there).
- Read with rsp_ready held 0 for 5 cycles after rsp_valid rises -> rsp_valid, rsp_rdata and rsp_err are constant and req_ready = 0 throughout. Completion occurs on the first edge with rsp_ready = 1. req_ready = 1 the next cycle.
- Write 0x0 to 0x030 and complete it. Then write 0xCAFEF00D to 0x030 and assert rst for 1 cycle while in BUSY. Read 0x030 after reset -> old value 0x0. rsp_valid is 0 after reset.
- WAIT_CYCLES = 0 build: back-to-back reads of 0x000 and 0x004 with req_valid and rsp_ready held 1 -> each response arrives 1 cycle after its accept. Accepts are 2 cycles apart.
